fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch and PC-sequencing stage directly upstream of the opcode decoder (control unit).
- Owns the PC register and the instruction register (IR), and fetches from instruction memory over a req/ack handshake.
- Presents opcode and instruction to the decoder, then consumes the decoder's ldPC/pcSel/jumpSel/branchSel and the ALU zero flag to select the next PC.

Parameters:
- PC_W, 12, word-address width of PC and imem_addr.
- INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1:INSTR_W-4].
- BR_OFF_W, 8, branch offset width; offset = instr[BR_OFF_W-1:0], two's complement.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  INSTR_W  fetched instruction
- instr  out  INSTR_W  IR contents
- opcode  out  4  IR[INSTR_W-1:INSTR_W-4], to decoder
- instr_valid  out  1  IR holds an instruction awaiting execution
- ld_pc  in  1  decoder: advance PC
- pc_sel  in  1  decoder: sequential PC+1
- jump_sel  in  1  decoder: absolute jump
- branch_sel  in  1  decoder: branch-if-zero
- alu_zero  in  1  ALU zero flag
- stall  in  1  datapath busy; hold the current instruction
- pc  out  PC_W  current PC
- pc_plus1  out  PC_W  pc+1, combinational, mod 2^PC_W
- halted  out  1  fetch stopped on an illegal opcode

Behaviour:
- Reset values: state=FETCH, pc=RESET_PC, IR=0, imem_req=0, instr_valid=0, halted=0. Reset overrides everything, including a mid-fetch request.
- imem_req is registered. It rises the cycle after entry to FETCH, so the first request after reset goes out at cycle 1.
- States: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack with imem_req=1: IR<=imem_rdata, imem_req<=0, go to EXEC.
  - An ack while imem_req=0 is ignored.
  - imem_addr is stable while imem_req=1.
- EXEC: instr_valid=1.
  - If stall=1: hold; IR, pc and state are unchanged.
  - If stall=0 and ld_pc=1: update pc, go to FETCH.
  - If stall=0 and ld_pc=0 (undefined opcode): go to HALT.
- Next-PC selection, priority high to low:
  - jump_sel: pc <= instr[PC_W-1:0].
  - branch_sel & alu_zero: pc <= pc+1+sext(offset).
  - branch_sel & !alu_zero: pc <= pc+1.
  - pc_sel: pc <= pc+1.
  - none of the above: pc <= pc+1.
- PC arithmetic is modulo 2^PC_W. Wrap-around in both directions is legal and silent.
- HALT: halted=1, imem_req=0, instr_valid=0; leaves only on rst.
- Minimum throughput: 2 cycles per instruction (ack on the first req cycle, no stall).
- Decoder select inputs are sampled only in EXEC with stall=0; they are don't-care elsewhere.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, add outputs:
  - retired_cnt[15:0]: increments on every EXEC cycle with stall=0 and ld_pc=1.
  - fetch_wait_cnt[15:0]: increments on every FETCH cycle with imem_req=1 and imem_ack=0.
  - Both counters saturate at 16'hFFFF and clear on rst.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encodings FETCH/EXEC/HALT;
  - opcode width constant (4) and the opcode field position;
  - PC_W/INSTR_W defaults.
- The opcode constants already used by the decoder move to the same package.
- One natural sub-module, next_pc_sel: combinational next-PC mux with sign extension and priority logic.

Test Plan:
- Reset then sequential fetch: rst for 2 cycles, ack every request immediately with pc_sel=1, ld_pc=1 → imem_addr sequence 0,1,2,3; retire every 2 cycles.
- Jump and branch: IR=16'h2_05A, jump_sel=1 → pc=12'h05A. At pc=12'h010, branch_sel=1 with offset 8'hFC:
  - alu_zero=1 → pc=12'h00D;
  - alu_zero=0 → pc=12'h011.
- Wrap and priority:
  - pc=12'hFFF, pc_sel → pc=12'h000.
  - jump_sel=1 and branch_sel=1 with alu_zero=1, target 12'h123 → pc=12'h123.
- Handshake and stall: hold ack low 5 cycles → imem_req and imem_addr stable, then IR loads on ack. stall=1 for 3 EXEC cycles → pc and IR unchanged, instr_valid=1 throughout.
- Illegal opcode and reset recovery: ld_pc=0 with stall=0 in EXEC → halted=1 next cycle, imem_req=0 indefinitely; rst → pc=RESET_PC, halted=0. rst during a pending fetch → imem_req=0 the next cycle and a late ack is ignored.
- FETCH_PERF_CNT_EN: 10 retirements with 3 wait cycles each → retired_cnt=10, fetch_wait_cnt=30.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// ============================================================================
// fetch_pc_unit_pkg : shared fetch-stage state encoding, field layout, opcodes
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_pc_unit_pkg;

   localparam int PC_W_DEF     = 12;
   localparam int INSTR_W_DEF  = 16;
   localparam int BR_OFF_W_DEF = 8;
   localparam int OPCODE_W     = 4;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_t;

   // Opcode map shared with the decoder; 4'hF is deliberately left undefined.
   localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_ALU = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_JMP = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_BRZ = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_LD  = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_ST  = 4'h6;

   // The opcode occupies the top OPCODE_W bits of the instruction.
   function automatic int opcode_lsb(input int instr_w);
      return instr_w - OPCODE_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
// ============================================================================
// fetch_pc_unit_if : instruction-memory req/ack fetch bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_pc_unit_if #(
   parameter int PC_W    = 12,
   parameter int INSTR_W = 16
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

`default_nettype wire

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// ============================================================================
// fetch_pc_unit_next_pc_sel : combinational next-PC priority mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit_next_pc_sel #(
   parameter int PC_W     = 12,
   parameter int BR_OFF_W = 8
) (
   input  wire logic [PC_W-1:0] pc,
   input  wire logic [PC_W-1:0] target,
   input  wire logic            jump_sel,
   input  wire logic            branch_sel,
   input  wire logic            alu_zero,
   input  wire logic            pc_sel,
   output logic      [PC_W-1:0] next_pc,
   output logic      [PC_W-1:0] pc_plus1
);

   logic [PC_W-1:0] br_off_sext;

   // Branch offset shares the low bits of the jump target field.
   assign br_off_sext = {{(PC_W-BR_OFF_W){target[BR_OFF_W-1]}}, target[BR_OFF_W-1:0]};
   assign pc_plus1    = pc + PC_W'(1);

   always_comb begin
      next_pc = pc_plus1;
      if (jump_sel) begin
         next_pc = target;
      end else if (branch_sel) begin
         next_pc = alu_zero ? (pc_plus1 + br_off_sext) : pc_plus1;
      end else if (pc_sel) begin
         next_pc = pc_plus1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit : PC/IR owner, imem fetch sequencing, next-PC update
// Optional perf counters when FETCH_PERF_CNT_EN is defined.  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              INSTR_W  = INSTR_W_DEF,
   parameter int              BR_OFF_W = BR_OFF_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   fetch_pc_unit_if.master           imem,
   output logic      [INSTR_W-1:0]   instr,
   output logic      [OPCODE_W-1:0]  opcode,
   output logic                      instr_valid,
   input  wire logic                 ld_pc,
   input  wire logic                 pc_sel,
   input  wire logic                 jump_sel,
   input  wire logic                 branch_sel,
   input  wire logic                 alu_zero,
   input  wire logic                 stall,
   output logic      [PC_W-1:0]      pc,
   output logic      [PC_W-1:0]      pc_plus1,
   output logic                      halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic      [15:0]          retired_cnt,
   output logic      [15:0]          fetch_wait_cnt
`endif
);

   localparam int OP_LSB = opcode_lsb(INSTR_W);

   fetch_state_t       state;
   logic               req_q;
   logic [INSTR_W-1:0] ir;
   logic [PC_W-1:0]    pc_q;
   logic [PC_W-1:0]    next_pc;
   logic               retire;
   logic               fetch_wait;

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign instr          = ir;
   assign opcode         = ir[OP_LSB +: OPCODE_W];
   assign pc             = pc_q;

   assign retire     = (state == ST_EXEC) && !stall && ld_pc;
   assign fetch_wait = (state == ST_FETCH) && req_q && !imem.imem_ack;

   fetch_pc_unit_next_pc_sel #(
      .PC_W     (PC_W),
      .BR_OFF_W (BR_OFF_W)
   ) u_next_pc_sel (
      .pc         (pc_q),
      .target     (ir[PC_W-1:0]),
      .jump_sel   (jump_sel),
      .branch_sel (branch_sel),
      .alu_zero   (alu_zero),
      .pc_sel     (pc_sel),
      .next_pc    (next_pc),
      .pc_plus1   (pc_plus1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_FETCH;
         pc_q        <= RESET_PC;
         ir          <= '0;
         req_q       <= 1'b0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (req_q) begin
                  if (imem.imem_ack) begin
                     ir          <= imem.imem_rdata;
                     req_q       <= 1'b0;
                     instr_valid <= 1'b1;
                     state       <= ST_EXEC;
                  end
               end else begin
                  req_q <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (!stall) begin
                  instr_valid <= 1'b0;
                  if (ld_pc) begin
                     // Request goes out with the new PC so fetch starts immediately.
                     pc_q  <= next_pc;
                     req_q <= 1'b1;
                     state <= ST_FETCH;
                  end else begin
                     halted <= 1'b1;
                     state  <= ST_HALT;
                  end
               end
            end
            ST_HALT: begin
               req_q       <= 1'b0;
               instr_valid <= 1'b0;
               halted      <= 1'b1;
            end
            default: begin
               req_q       <= 1'b0;
               instr_valid <= 1'b0;
               state       <= ST_FETCH;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_cnt    <= '0;
         fetch_wait_cnt <= '0;
      end else begin
         if (retire && (retired_cnt != 16'hFFFF)) begin
            retired_cnt <= retired_cnt + 16'd1;
         end
         if (fetch_wait && (fetch_wait_cnt != 16'hFFFF)) begin
            fetch_wait_cnt <= fetch_wait_cnt + 16'd1;
         end
      end
   end
`else
   logic unused_perf;
   assign unused_perf = retire ^ fetch_wait;
`endif

endmodule

`default_nettype wire
